// File: rtl/mem_if.sv
// Control-unit <-> memory bus bundle: request strobes, address/data and the
// busy/ready/err handshake returned by the memory stage.
interface mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_interface.sv
// Memory stage behind the control unit: single-port RAM with programmable
// wait states, busy/ready handshake, illegal-request flag and a preload port.
module mem_interface #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_if.slave              bus,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              accept_s;
  logic              illegal_s;
  logic              bus_idle_s;

  // A request is taken only once per level: armed must be re-set by a quiet bus.
  assign bus_idle_s = ~bus.mem_read & ~bus.mem_write;
  assign accept_s   = (state_q == ST_IDLE) & armed_q & (bus.mem_read ^ bus.mem_write);
  assign illegal_s  = (state_q == ST_IDLE) & armed_q & bus.mem_read & bus.mem_write;

  // Next-state, handshake and RAM write-port selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    ram_we_s    = 1'b0;
    ram_waddr_s = init_addr;
    ram_wdata_s = init_data;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d     = bus.addr;
          wdata_d    = bus.wdata;
          is_write_d = bus.mem_write;
          cnt_d      = WAIT_INIT;
          busy_d     = 1'b1;
          state_d    = ST_ACCESS;
        end else begin
          err_d    = illegal_s;
          ram_we_s = init_we;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_write_q) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = addr_q;
            ram_wdata_s = wdata_q;
          end else begin
            rdata_d = ram_q[addr_q];
          end
          ready_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (bus_idle_s) begin
      armed_d = 1'b1;
    end else if (accept_s || illegal_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= {DATA_W{1'b0}};
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b1;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
    end
  end

  // RAM has no reset; holding reset blocks any write so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      ram_q[ram_waddr_s] <= ram_wdata_s;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Drives a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance with the same stimulus and
// checks both every cycle against a timestamp-based transaction model.
module tb_mem_interface;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.mem_read  = rd;
  assign bus_a.mem_write = wr;
  assign bus_a.addr      = addr;
  assign bus_a.wdata     = wdata;
  assign bus_b.mem_read  = rd;
  assign bus_b.mem_write = wr;
  assign bus_b.addr      = addr;
  assign bus_b.wdata     = wdata;

  mem_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W0)) u_dut_w2 (
    .clk(clk), .reset(reset), .bus(bus_a),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  mem_interface #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) u_dut_w0 (
    .clk(clk), .reset(reset), .bus(bus_b),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  // Reference model state, index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0
  int            wt [2];
  logic [DW-1:0] mram [0:1][0:255];
  bit            m_armed [2];
  bit            m_inflight [2];
  bit            m_is_wr [2];
  int            m_t0 [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] e_rdata [2];
  bit            e_ready [2];
  bit            e_busy [2];
  bit            e_err [2];
  int            obs_ready [2];
  int            obs_err [2];
  int            n;
  int            n_cmp;
  int            n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_armed[k]    = 1'b1;
      m_inflight[k] = 1'b0;
      e_rdata[k]    = '0;
      e_ready[k]    = 1'b0;
      e_busy[k]     = 1'b0;
      e_err[k]      = 1'b0;
    end
  endtask

  // One rising edge: completion happens W+1 edges after acceptance, idle again at W+2.
  task automatic model_edge();
    bit acc;
    n++;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_ready[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (m_inflight[k]) begin
          if (n == m_t0[k] + wt[k] + 1) begin
            if (m_is_wr[k]) mram[k][m_addr[k]] = m_wdata[k];
            else e_rdata[k] = mram[k][m_addr[k]];
            e_ready[k] = 1'b1;
          end else if (n == m_t0[k] + wt[k] + 2) begin
            m_inflight[k] = 1'b0;
          end
        end else begin
          acc = 1'b0;
          if (m_armed[k] && (rd ^ wr)) begin
            acc           = 1'b1;
            m_t0[k]       = n;
            m_addr[k]     = addr;
            m_wdata[k]    = wdata;
            m_is_wr[k]    = wr;
            m_inflight[k] = 1'b1;
            m_armed[k]    = 1'b0;
          end else if (m_armed[k] && rd && wr) begin
            e_err[k]   = 1'b1;
            m_armed[k] = 1'b0;
          end
          if (!acc && init_we) mram[k][init_addr] = init_data;
        end
        e_busy[k] = m_inflight[k];
        if (!rd && !wr) m_armed[k] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("w2.rdata", 32'(bus_a.rdata), 32'(e_rdata[0]));
    chk("w2.ready", 32'(bus_a.ready), 32'(e_ready[0]));
    chk("w2.busy",  32'(bus_a.busy),  32'(e_busy[0]));
    chk("w2.err",   32'(bus_a.err),   32'(e_err[0]));
    chk("w0.rdata", 32'(bus_b.rdata), 32'(e_rdata[1]));
    chk("w0.ready", 32'(bus_b.ready), 32'(e_ready[1]));
    chk("w0.busy",  32'(bus_b.busy),  32'(e_busy[1]));
    chk("w0.err",   32'(bus_b.err),   32'(e_err[1]));
    chk("w2.rdy_and_err", 32'(bus_a.ready & bus_a.err), 32'd0);
    chk("w0.rdy_and_err", 32'(bus_b.ready & bus_b.err), 32'd0);
    if (bus_a.ready === 1'b1) obs_ready[0]++;
    if (bus_b.ready === 1'b1) obs_ready[1]++;
    if (bus_a.err === 1'b1) obs_err[0]++;
    if (bus_b.err === 1'b1) obs_err[1]++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    step();
    init_we   = 1'b0;
  endtask

  // One-cycle read pulse, then enough idle time for the slow instance to finish.
  task automatic read_pulse(input logic [AW-1:0] a);
    addr = a;
    rd   = 1'b1;
    step();
    rd   = 1'b0;
    steps(6);
  endtask

  int r0;
  int r1;
  int e0;
  int e1;

  initial begin
    wt[0] = W0;
    wt[1] = W1;
    n = 0; n_cmp = 0; n_bad = 0;
    obs_ready[0] = 0; obs_ready[1] = 0; obs_err[0] = 0; obs_err[1] = 0;
    reset = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #1;
    chk("rst.rdata", 32'(bus_a.rdata), 32'd0);
    chk("rst.ready", 32'(bus_a.ready), 32'd0);
    chk("rst.busy",  32'(bus_b.busy),  32'd0);
    chk("rst.err",   32'(bus_b.err),   32'd0);
    steps(2);
    reset = 1'b0;
    step();

    // Fill the whole RAM so every later read has a defined value
    for (int i = 0; i < 256; i++) preload(AW'(i), DW'(i * 257) ^ 16'h5A3C);
    preload(8'h10, 16'h8A31);
    preload(8'h30, 16'h1234);
    preload(8'h40, 16'h0001);

    // Preload and read
    r0 = obs_ready[0]; r1 = obs_ready[1];
    read_pulse(8'h10);
    chk("pl.rdata.w2", 32'(bus_a.rdata), 32'h8A31);
    chk("pl.rdata.w0", 32'(bus_b.rdata), 32'h8A31);
    chk("pl.nready.w2", 32'(obs_ready[0] - r0), 32'd1);
    chk("pl.nready.w0", 32'(obs_ready[1] - r1), 32'd1);

    // Write held until ready, then read it back
    r0 = obs_ready[0]; r1 = obs_ready[1];
    addr = 8'h20; wdata = 16'hBEEF; wr = 1'b1;
    steps(5);
    wr = 1'b0; wdata = 16'h0000;
    steps(2);
    chk("wr.nready.w2", 32'(obs_ready[0] - r0), 32'd1);
    chk("wr.nready.w0", 32'(obs_ready[1] - r1), 32'd1);
    read_pulse(8'h20);
    chk("wr.rdback.w2", 32'(bus_a.rdata), 32'hBEEF);
    chk("wr.rdback.w0", 32'(bus_b.rdata), 32'hBEEF);

    // Held level gives one access; drop for one cycle and rise gives a second
    r0 = obs_ready[0]; r1 = obs_ready[1];
    addr = 8'h05; rd = 1'b1;
    steps(8);
    chk("held.nready.w2", 32'(obs_ready[0] - r0), 32'd1);
    chk("held.nready.w0", 32'(obs_ready[1] - r1), 32'd1);
    rd = 1'b0; step();
    rd = 1'b1; step();
    rd = 1'b0; steps(5);
    chk("held2.nready.w2", 32'(obs_ready[0] - r0), 32'd2);
    chk("held2.nready.w0", 32'(obs_ready[1] - r1), 32'd2);

    // Illegal request
    r0 = obs_ready[0]; r1 = obs_ready[1]; e0 = obs_err[0]; e1 = obs_err[1];
    addr = 8'h30; wdata = 16'hDEAD; rd = 1'b1; wr = 1'b1;
    steps(3);
    rd = 1'b0; wr = 1'b0;
    steps(3);
    chk("ill.nerr.w2", 32'(obs_err[0] - e0), 32'd1);
    chk("ill.nerr.w0", 32'(obs_err[1] - e1), 32'd1);
    chk("ill.nready.w2", 32'(obs_ready[0] - r0), 32'd0);
    chk("ill.nready.w0", 32'(obs_ready[1] - r1), 32'd0);
    read_pulse(8'h30);
    chk("ill.ram.w2", 32'(bus_a.rdata), 32'h1234);
    chk("ill.ram.w0", 32'(bus_b.rdata), 32'h1234);

    // Reset in the middle of a write
    addr = 8'h40; wdata = 16'h5555; wr = 1'b1;
    step();
    wr = 1'b0; reset = 1'b1;
    model_reset();
    #1;
    chk("rstmid.busy.w2",  32'(bus_a.busy),  32'd0);
    chk("rstmid.ready.w2", 32'(bus_a.ready), 32'd0);
    chk("rstmid.rdata.w2", 32'(bus_a.rdata), 32'd0);
    chk("rstmid.busy.w0",  32'(bus_b.busy),  32'd0);
    step();
    reset = 1'b0;
    steps(2);
    read_pulse(8'h40);
    chk("rstmid.ram.w2", 32'(bus_a.rdata), 32'h0001);
    chk("rstmid.ram.w0", 32'(bus_b.rdata), 32'h0001);

    // Zero-wait instance: request/drop/request completes two reads in 6 cycles
    r1 = obs_ready[1];
    addr = 8'h10; rd = 1'b1; step();
    rd = 1'b0; step();
    addr = 8'h20; rd = 1'b1; steps(2);
    rd = 1'b0; steps(2);
    chk("b2b.nready.w0", 32'(obs_ready[1] - r1), 32'd2);
    chk("b2b.rdata.w0", 32'(bus_b.rdata), 32'hBEEF);
    steps(4);

    // Randomized traffic over a small address window, with rare resets
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      rd        = ($urandom_range(0, 2) == 0);
      wr        = ($urandom_range(0, 3) == 0);
      addr      = AW'($urandom_range(0, 31));
      wdata     = DW'($urandom);
      init_we   = ($urandom_range(0, 7) == 0);
      init_addr = AW'($urandom_range(0, 31));
      init_data = DW'($urandom);
      step();
    end
    reset = 1'b0; rd = 1'b0; wr = 1'b0; init_we = 1'b0;
    steps(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
